mfm_read_sequencer: RTL and testbench

MFM_READ_SEQUENCER -- requirements
Module: mfm_read_sequencer

---
 rtl/mfm_read_sequencer.sv | 175 +++++++++++++++++
 tb/tb_mfm_read_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfm_read_sequencer.sv
// MFM read sequencer: hunts for a run of sync marks in the recovered cell stream,
// then frames (clock, data) cell pairs into bytes until a full sector is read.
module mfm_read_sequencer #(
  parameter logic [15:0] SYNC_WORD     = 16'h4489,
  parameter int          SYNC_MARKS    = 3,
  parameter int          SECTOR_BYTES  = 512,
  parameter int          TIMEOUT_CELLS = 65535
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       cell_strobe,
  input  logic       cell_value,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic [9:0] byte_count,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HUNT,
    ST_SYNC,
    ST_FRAME,
    ST_DONE,
    ST_FAIL
  } state_t;

  localparam logic [2:0]  SYNC_MARKS_L = 3'(SYNC_MARKS);
  localparam logic [9:0]  SECTOR_L     = 10'(SECTOR_BYTES);
  localparam logic [15:0] TIMEOUT_L    = 16'(TIMEOUT_CELLS);

  state_t      state_q,      state_d;
  logic [14:0] window_q,     window_d;
  logic [2:0]  sync_cnt_q,   sync_cnt_d;
  logic [3:0]  phase_q,      phase_d;
  logic [15:0] tmo_q,        tmo_d;
  logic [6:0]  data_q,       data_d;
  logic [7:0]  byte_out_q,   byte_out_d;
  logic        byte_valid_q, byte_valid_d;
  logic [9:0]  byte_count_q, byte_count_d;

  // Only the older 15 cells are stored; the live 16-cell window always includes
  // the cell arriving this cycle, so matches are seen on the strobe itself.
  logic [15:0] win_next;
  logic [15:0] tmo_next;
  logic        timed_out;

  assign win_next  = {window_q, cell_value};
  assign tmo_next  = tmo_q + 16'd1;
  assign timed_out = (tmo_next == TIMEOUT_L);

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    window_d     = window_q;
    sync_cnt_d   = sync_cnt_q;
    phase_d      = phase_q;
    tmo_d        = tmo_q;
    data_d       = data_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = 1'b0;
    byte_count_d = byte_count_q;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d      = ST_HUNT;
            window_d     = '0;
            sync_cnt_d   = '0;
            phase_d      = '0;
            tmo_d        = '0;
            data_d       = '0;
            byte_count_d = '0;
          end
        end

        ST_HUNT: begin
          if (cell_strobe) begin
            window_d = win_next[14:0];
            tmo_d    = tmo_next;
            if (timed_out) begin
              state_d = ST_FAIL;
            end else if (win_next == SYNC_WORD) begin
              sync_cnt_d = 3'd1;
              phase_d    = '0;
              state_d    = (SYNC_MARKS_L == 3'd1) ? ST_FRAME : ST_SYNC;
            end
          end
        end

        ST_SYNC: begin
          if (cell_strobe) begin
            window_d = win_next[14:0];
            tmo_d    = tmo_next;
            phase_d  = phase_q + 4'd1;
            if (timed_out) begin
              state_d = ST_FAIL;
            end else if (phase_q == 4'd15) begin
              if (win_next == SYNC_WORD) begin
                sync_cnt_d = sync_cnt_q + 3'd1;
                if (sync_cnt_q + 3'd1 == SYNC_MARKS_L) state_d = ST_FRAME;
              end else begin
                sync_cnt_d = '0;
                state_d    = ST_HUNT;
              end
            end
          end
        end

        ST_FRAME: begin
          if (cell_strobe) begin
            window_d = win_next[14:0];
            phase_d  = phase_q + 4'd1;
            // Odd phases are data cells; the phase wraps to 0 after the last mark.
            if (phase_q[0]) data_d = {data_q[5:0], cell_value};
            if (cell_value && window_q[0]) begin
              state_d = ST_FAIL;
            end else if (phase_q == 4'd15) begin
              byte_out_d   = {data_q, cell_value};
              byte_valid_d = 1'b1;
              byte_count_d = byte_count_q + 10'd1;
              if (byte_count_q + 10'd1 == SECTOR_L) state_d = ST_DONE;
            end
          end
        end

        ST_DONE: state_d = ST_IDLE;
        ST_FAIL: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      window_q     <= '0;
      sync_cnt_q   <= '0;
      phase_q      <= '0;
      tmo_q        <= '0;
      data_q       <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      window_q     <= window_d;
      sync_cnt_q   <= sync_cnt_d;
      phase_q      <= phase_d;
      tmo_q        <= tmo_d;
      data_q       <= data_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign busy       = (state_q == ST_HUNT) || (state_q == ST_SYNC) || (state_q == ST_FRAME);
  assign done       = (state_q == ST_DONE);
  assign error      = (state_q == ST_FAIL);
  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_mfm_read_sequencer.sv
// Bench for mfm_read_sequencer: table of two-byte sectors checked through a byte
// scoreboard, plus hand sequences for resync, timeout, violations, abort and reset.
module tb_mfm_read_sequencer;

  logic clk_50 = 1'b0;
  logic reset, cell_strobe, cell_value, start, abort;

  logic       a_busy, a_byte_valid, a_done, a_error;
  logic [7:0] a_byte_out;
  logic [9:0] a_byte_count;
  logic       t_busy, t_byte_valid, t_done, t_error;
  logic [7:0] t_byte_out;
  logic [9:0] t_byte_count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] count;
    logic       done;
  } exp_t;

  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[4];

  localparam logic [15:0] SYNC = 16'h4489;

  always #10 clk_50 = ~clk_50;

  mfm_read_sequencer #(
    .SYNC_WORD(16'h4489), .SYNC_MARKS(3), .SECTOR_BYTES(2), .TIMEOUT_CELLS(65535)
  ) dut_a (
    .clk_50(clk_50), .reset(reset), .cell_strobe(cell_strobe), .cell_value(cell_value),
    .start(start), .abort(abort), .busy(a_busy), .byte_out(a_byte_out),
    .byte_valid(a_byte_valid), .byte_count(a_byte_count), .done(a_done), .error(a_error)
  );

  // Single-mark, single-byte, short-timeout variant sharing the same stimulus.
  mfm_read_sequencer #(
    .SYNC_WORD(16'h4489), .SYNC_MARKS(1), .SECTOR_BYTES(1), .TIMEOUT_CELLS(64)
  ) dut_t (
    .clk_50(clk_50), .reset(reset), .cell_strobe(cell_strobe), .cell_value(cell_value),
    .start(start), .abort(abort), .busy(t_busy), .byte_out(t_byte_out),
    .byte_valid(t_byte_valid), .byte_count(t_byte_count), .done(t_done), .error(t_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every byte strobe must match the oldest pending expectation.
  always @(negedge clk_50) begin
    if (a_byte_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_byte_valid", a_byte_valid, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("byte_out", a_byte_out, e.data);
        check("byte_count", a_byte_count, e.count);
        check("done_with_byte", a_done, e.done);
      end
    end else if (a_done) begin
      check("done_without_byte", a_done, 1'b0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_50);
      #1;
    end
  endtask

  task automatic send_cell(input logic v);
    cell_value  = v;
    cell_strobe = 1'b1;
    @(posedge clk_50);
    #1;
    cell_strobe = 1'b0;
    cell_value  = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) begin
      send_cell(w[i]);
      idle(1);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    idle(1);
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    idle(1);
    abort = 1'b0;
  endtask

  task automatic start_and_sync();
    pulse_start();
    repeat (3) send_word(SYNC);
  endtask

  task automatic run_sector(input vec_t v);
    start_and_sync();
    sb.push_back('{data: v.b0, count: 10'd1, done: 1'b0});
    send_word(v.w0);
    sb.push_back('{data: v.b1, count: 10'd2, done: 1'b1});
    send_word(v.w1);
    idle(2);
    check("busy_after_sector", a_busy, 1'b0);
    check("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    logic [15:0] w;

    vecs[0] = '{16'h2AAA, 16'h5555, 8'h00, 8'hFF};
    vecs[1] = '{16'h5555, 16'h2AAA, 8'hFF, 8'h00};
    vecs[2] = '{16'h1144, 16'h4489, 8'h5A, 8'hA1};
    vecs[3] = '{16'h4489, 16'h1144, 8'hA1, 8'h5A};

    reset = 1'b1; cell_strobe = 1'b0; cell_value = 1'b0; start = 1'b0; abort = 1'b0;
    #5;
    check("rst_busy", a_busy, 1'b0);
    check("rst_byte_out", a_byte_out, 8'h00);
    check("rst_byte_valid", a_byte_valid, 1'b0);
    check("rst_byte_count", a_byte_count, 10'd0);
    check("rst_done", a_done, 1'b0);
    check("rst_error", a_error, 1'b0);
    @(posedge clk_50);
    #1;
    reset = 1'b0;
    idle(2);

    // Table of full sectors; the single-mark variant frames the second mark as A1.
    for (int k = 0; k < 4; k++) begin
      run_sector(vecs[k]);
      check("single_mark_byte", t_byte_out, 8'hA1);
      check("single_mark_count", t_byte_count, 10'd1);
      check("single_mark_idle", t_busy, 1'b0);
    end

    // Broken mark run falls back to hunting; framing needs three fresh marks.
    pulse_start();
    send_word(SYNC);
    send_word(SYNC);
    send_word(16'h1234);
    check("resync_busy", a_busy, 1'b1);
    repeat (3) send_word(SYNC);
    sb.push_back('{data: 8'h00, count: 10'd1, done: 1'b0});
    send_word(16'h2AAA);
    sb.push_back('{data: 8'hFF, count: 10'd2, done: 1'b1});
    send_word(16'h5555);
    idle(2);
    check("resync_drained", sb.size(), 0);
    check("resync_idle", a_busy, 1'b0);

    // Hunt timeout on the 64-cell variant.
    pulse_start();
    repeat (63) begin
      send_cell(1'b0);
      idle(1);
    end
    check("tmo_busy_before", t_busy, 1'b1);
    check("tmo_error_before", t_error, 1'b0);
    send_cell(1'b0);
    check("tmo_error", t_error, 1'b1);
    check("tmo_busy", t_busy, 1'b0);
    check("tmo_count", t_byte_count, 10'd0);
    idle(1);
    check("tmo_error_one_cycle", t_error, 1'b0);
    pulse_abort();
    check("tmo_a_aborted", a_busy, 1'b0);

    // Consecutive ones inside the first data byte.
    start_and_sync();
    w = 16'h6000;
    send_cell(w[15]); idle(1);
    send_cell(w[14]); idle(1);
    check("viol_no_error_yet", a_error, 1'b0);
    send_cell(w[13]);
    check("viol_error", a_error, 1'b1);
    check("viol_busy", a_busy, 1'b0);
    idle(1);
    check("viol_error_one_cycle", a_error, 1'b0);
    for (int i = 12; i >= 0; i--) begin
      send_cell(w[i]);
      idle(1);
    end
    check("viol_discard_busy", a_busy, 1'b0);
    check("viol_count", a_byte_count, 10'd0);

    // Last mark cell is 1, so a leading 1 cell is a violation.
    start_and_sync();
    send_cell(1'b1);
    check("sync_edge_error", a_error, 1'b1);
    idle(2);

    // Violation across a byte boundary after one good byte.
    start_and_sync();
    sb.push_back('{data: 8'hFF, count: 10'd1, done: 1'b0});
    send_word(16'h5555);
    send_cell(1'b1);
    check("byte_edge_error", a_error, 1'b1);
    check("byte_edge_count", a_byte_count, 10'd1);
    idle(2);

    // Abort beats start in IDLE.
    abort = 1'b1; start = 1'b1;
    idle(1);
    abort = 1'b0; start = 1'b0;
    check("abort_start_a", a_busy, 1'b0);
    check("abort_start_t", t_busy, 1'b0);

    // Abort coincident with the strobe that would complete the second byte.
    start_and_sync();
    sb.push_back('{data: 8'h00, count: 10'd1, done: 1'b0});
    send_word(16'h2AAA);
    w = 16'h5555;
    for (int i = 15; i >= 1; i--) begin
      send_cell(w[i]);
      idle(1);
    end
    cell_value = w[0]; cell_strobe = 1'b1; abort = 1'b1;
    idle(1);
    cell_value = 1'b0; cell_strobe = 1'b0; abort = 1'b0;
    check("abort_busy", a_busy, 1'b0);
    check("abort_done", a_done, 1'b0);
    check("abort_error", a_error, 1'b0);
    check("abort_count", a_byte_count, 10'd1);
    idle(2);
    check("abort_error_later", a_error, 1'b0);

    // Reset mid-byte, then a clean sector.
    start_and_sync();
    sb.push_back('{data: 8'hFF, count: 10'd1, done: 1'b0});
    send_word(16'h5555);
    w = 16'h2AAA;
    for (int i = 15; i >= 8; i--) begin
      send_cell(w[i]);
      idle(1);
    end
    #3;
    reset = 1'b1;
    #1;
    check("midrst_busy", a_busy, 1'b0);
    check("midrst_byte_out", a_byte_out, 8'h00);
    check("midrst_byte_valid", a_byte_valid, 1'b0);
    check("midrst_count", a_byte_count, 10'd0);
    check("midrst_done", a_done, 1'b0);
    check("midrst_error", a_error, 1'b0);
    @(posedge clk_50);
    #1;
    reset = 1'b0;
    idle(3);
    run_sector(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
